bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared system bus. The IF-stage bus interface, the MEM-stage bus interface and up to two further masters (DMA, debug) compete for that bus.
- Consumes each master's active-low bus_req_. Drives the one-hot active-low bus_grnt_ that the bus interfaces wait on before issuing bus_as_.
- Also drives the owner index used by the address/data mux in the bus top.
- Grant is registered. The current owner keeps the bus until it deasserts its request (transfer-atomic).

---
 rtl/bus_arbiter.sv | 97 +++++++++
 tb/tb_bus_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus with registered, active-low one-hot grant.
// Define BUS_ARB_PREEMPT_EN to add the hold counter that forces handover after MAX_HOLD cycles.
module bus_arbiter #(
  parameter int unsigned MASTER_CNT = 4,
  parameter int unsigned OWNER_W    = 2,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MASTER_CNT-1:0] m_req_,
  output logic [MASTER_CNT-1:0] m_grnt_,
  output logic [OWNER_W-1:0]    owner,
  output logic                  bus_busy,
  output logic                  preempt
);

  if (OWNER_W != $clog2(MASTER_CNT)) begin : g_bad_owner_w
    $error("bus_arbiter: OWNER_W must equal clog2(MASTER_CNT)");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 32) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must fit the 5-bit hold counter");
  end

  logic [OWNER_W-1:0]    owner_q, owner_d;
  logic [OWNER_W-1:0]    pick;
  logic [MASTER_CNT-1:0] grnt_q, grnt_d;
  logic                  owner_req;
  logic                  found;
  logic                  force_handover;

  assign owner_req = ~m_req_[owner_q];

  // Search owner+1 .. owner+CNT-1; the owner itself is covered by the hold path.
  always_comb begin
    pick  = owner_q;
    found = 1'b0;
    for (int unsigned k = 1; k < MASTER_CNT; k++) begin
      if (!found && !m_req_[owner_q + OWNER_W'(k)]) begin
        found = 1'b1;
        pick  = owner_q + OWNER_W'(k);
      end
    end
  end

  always_comb begin
    owner_d = owner_q;
    if ((!owner_req || force_handover) && found) begin
      owner_d = pick;
    end
    grnt_d = ~(MASTER_CNT'(1) << owner_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= '0;
      grnt_q  <= {{(MASTER_CNT-1){1'b1}}, 1'b0};
    end else begin
      owner_q <= owner_d;
      grnt_q  <= grnt_d;
    end
  end

  assign owner    = owner_q;
  assign m_grnt_  = grnt_q;
  assign bus_busy = owner_req;

`ifdef BUS_ARB_PREEMPT_EN
  logic [4:0] hold_q, hold_d;
  logic       preempt_q;

  assign force_handover = owner_req && found && (hold_q == 5'(MAX_HOLD - 1));

  // Count only contended ownership; any handover or lull restarts the window.
  always_comb begin
    hold_d = hold_q + 5'd1;
    if ((owner_d != owner_q) || !(owner_req && found)) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= force_handover;
    end
  end

  assign preempt = preempt_q;
`else
  assign force_handover = 1'b0;
  assign preempt        = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; expected values are hand-computed constants.
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] m_req_;
  logic [3:0] m_grnt_;
  logic [1:0] owner;
  logic       bus_busy;
  logic       preempt;

  int checks;
  int failures;

  bus_arbiter #(
    .MASTER_CNT(4),
    .OWNER_W   (2),
    .MAX_HOLD  (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req_  (m_req_),
    .m_grnt_ (m_grnt_),
    .owner   (owner),
    .bus_busy(bus_busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    m_req_ = 4'b1111;
    repeat (3) step();
    checks++;
    if (m_grnt_ !== 4'b1110 || owner !== 2'd0 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold grnt=%b owner=%0d preempt=%b want 1110/0/0",
               m_grnt_, owner, preempt);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (m_grnt_ !== 4'b1110 || owner !== 2'd0 || bus_busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_park cyc=%0d grnt=%b owner=%0d busy=%b want 1110/0/0",
                 i, m_grnt_, owner, bus_busy);
      end
    end
  endtask

  task automatic test_single_request();
    m_req_ = 4'b1011;
    step();
    checks++;
    if (m_grnt_ !== 4'b1011 || owner !== 2'd2 || bus_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant grnt=%b owner=%0d busy=%b want 1011/2/1",
               m_grnt_, owner, bus_busy);
    end
    repeat (3) step();
    m_req_ = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (m_grnt_ !== 4'b1011 || owner !== 2'd2 || bus_busy !== 1'b0) begin
        failures++;
        $display("FAIL park_after_release cyc=%0d grnt=%b owner=%0d busy=%b want 1011/2/0",
                 i, m_grnt_, owner, bus_busy);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_owner [3];
    logic [3:0] exp_grnt  [3];
    exp_owner = '{2'd3, 2'd0, 2'd1};
    exp_grnt  = '{4'b0111, 4'b1110, 4'b1101};
    m_req_ = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        checks++;
        if (m_grnt_ !== exp_grnt[n] || owner !== exp_owner[n] ||
            $countones(~m_grnt_) != 1) begin
          failures++;
          $display("FAIL rr_order n=%0d cyc=%0d grnt=%b owner=%0d want %b/%0d",
                   n, c, m_grnt_, owner, exp_grnt[n], exp_owner[n]);
        end
      end
      m_req_[exp_owner[n]] = 1'b1;
    end
    step();
    checks++;
    if (m_grnt_ !== 4'b1101 || owner !== 2'd1 || bus_busy !== 1'b0) begin
      failures++;
      $display("FAIL rr_park grnt=%b owner=%0d busy=%b want 1101/1/0", m_grnt_, owner, bus_busy);
    end
  endtask

  task automatic test_back_to_back();
    m_req_ = 4'b1101;
    step();
    m_req_ = 4'b1110;
    step();
    checks++;
    if (m_grnt_ !== 4'b1110 || owner !== 2'd0) begin
      failures++;
      $display("FAIL b2b_handover grnt=%b owner=%0d want 1110/0", m_grnt_, owner);
    end
    m_req_ = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (m_grnt_ !== 4'b1110 || owner !== 2'd0) begin
        failures++;
        $display("FAIL b2b_rerequest_wait cyc=%0d grnt=%b owner=%0d want 1110/0",
                 i, m_grnt_, owner);
      end
    end
    m_req_ = 4'b1101;
    step();
    checks++;
    if (m_grnt_ !== 4'b1101 || owner !== 2'd1 || bus_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_return grnt=%b owner=%0d busy=%b want 1101/1/1", m_grnt_, owner, bus_busy);
    end
    m_req_ = 4'b1111;
    step();
  endtask

  task automatic test_async_reset();
    m_req_ = 4'b0111;
    step();
    checks++;
    if (m_grnt_ !== 4'b0111 || owner !== 2'd3) begin
      failures++;
      $display("FAIL pre_reset_owner grnt=%b owner=%0d want 0111/3", m_grnt_, owner);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (m_grnt_ !== 4'b1110 || owner !== 2'd0 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL async_reset grnt=%b owner=%0d preempt=%b want 1110/0/0",
               m_grnt_, owner, preempt);
    end
    m_req_ = 4'b1111;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_preempt();
    m_req_ = 4'b1100;
`ifdef BUS_ARB_PREEMPT_EN
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++;
      if (owner !== 2'd0 || preempt !== 1'b0) begin
        failures++;
        $display("FAIL preempt_hold cyc=%0d owner=%0d preempt=%b want 0/0", i, owner, preempt);
      end
    end
    step();
    checks++;
    if (m_grnt_ !== 4'b1101 || owner !== 2'd1 || preempt !== 1'b1) begin
      failures++;
      $display("FAIL preempt_force grnt=%b owner=%0d preempt=%b want 1101/1/1",
               m_grnt_, owner, preempt);
    end
    step();
    checks++;
    if (owner !== 2'd1 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL preempt_pulse owner=%0d preempt=%b want 1/0", owner, preempt);
    end
`else
    for (int i = 1; i <= 100; i++) begin
      step();
      checks++;
      if (m_grnt_ !== 4'b1110 || owner !== 2'd0 || preempt !== 1'b0) begin
        failures++;
        $display("FAIL no_preempt cyc=%0d grnt=%b owner=%0d preempt=%b want 1110/0/0",
                 i, m_grnt_, owner, preempt);
      end
    end
`endif
    m_req_ = 4'b1111;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    m_req_   = 4'b1111;
    test_reset();
    test_single_request();
    test_round_robin();
    test_back_to_back();
    test_async_reset();
    test_preempt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
